// File: rtl/piso_shifter.sv
// Parallel-in serial-out shifter: captures a WIDTH-bit word on load and
// emits it one bit per cycle in the selected order, with back-to-back reload.
module piso_shifter #(
    parameter int WIDTH     = 6,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     load,
    input  logic [WIDTH-1:0]         data_in,
    output logic                     ready,
    output logic                     sout,
    output logic                     sout_valid,
    output logic                     done,
    output logic [$clog2(WIDTH)-1:0] remaining
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   shreg, shreg_next;
    logic               sout_next;
    logic               valid_next;
    logic [CNT_W-1:0]   remaining_next;
    logic               accept;

    // Bit that leaves the word first in the selected order.
    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Moves the word one place toward the send end, filling with zero.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // The last-bit cycle can accept a new word so streams run without gaps.
    assign ready  = (state == IDLE) || (remaining == '0);
    assign done   = (state == SHIFT) && (remaining == '0);
    assign accept = load && ready;

    always_comb begin
        state_next     = state;
        shreg_next     = shreg;
        sout_next      = sout;
        valid_next     = sout_valid;
        remaining_next = remaining;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next     = SHIFT;
                    sout_next      = head(data_in);
                    shreg_next     = advance(data_in);
                    valid_next     = 1'b1;
                    remaining_next = LAST_IDX;
                end
            end
            SHIFT: begin
                if (remaining != '0) begin
                    sout_next      = head(shreg);
                    shreg_next     = advance(shreg);
                    remaining_next = remaining - 1'b1;
                end else if (accept) begin
                    sout_next      = head(data_in);
                    shreg_next     = advance(data_in);
                    valid_next     = 1'b1;
                    remaining_next = LAST_IDX;
                end else begin
                    state_next     = IDLE;
                    sout_next      = 1'b0;
                    shreg_next     = '0;
                    valid_next     = 1'b0;
                    remaining_next = '0;
                end
            end
            default: begin
                state_next     = IDLE;
                sout_next      = 1'b0;
                shreg_next     = '0;
                valid_next     = 1'b0;
                remaining_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state      <= IDLE;
            shreg      <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            remaining  <= '0;
        end else begin
            state      <= state_next;
            shreg      <= shreg_next;
            sout       <= sout_next;
            sout_valid <= valid_next;
            remaining  <= remaining_next;
        end
    end

endmodule

// File: doc/piso_shifter.md
PISO_SHIFTER -- requirements
Module: piso_shifter

Interface
REQ-001 Parameter WIDTH, default 6, sets the number of bits per word; it SHALL be legal for any value 2..16.
REQ-002 Parameter MSB_FIRST, default 1, selects bit order: 1 sends data_in[WIDTH-1] first, 0 sends data_in[0] first.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
  clk         input   1                      single clock; all state changes on its rising edge
  clear       input   1                      reset, synchronous, active-high
  load        input   1                      request to accept data_in
  data_in     input   WIDTH                  parallel word to serialize
  ready       output  1                      block accepts load this cycle
  sout        output  1                      serial data bit, registered
  sout_valid  output  1                      sout carries a valid data bit, registered
  done        output  1                      one-cycle pulse marking the last bit of a word
  remaining   output  $clog2(WIDTH)          bits still to follow the bit now on sout

Function
REQ-004 The block SHALL have two states: IDLE and SHIFT.
REQ-005 In IDLE: ready=1, sout=0, sout_valid=0, done=0, remaining=0.
REQ-006 Accept: at an edge where load=1 and ready=1, the block SHALL capture data_in.
REQ-007 On accept, at that same edge, the block SHALL enter SHIFT and drive the first bit on sout, with sout_valid=1 and remaining=WIDTH-1.
REQ-008 In SHIFT, each subsequent edge SHALL present the next bit in the selected order and decrement remaining by 1.
REQ-009 Latency: with load sampled at edge N, bit k (k=0..WIDTH-1 in send order) SHALL be on sout during the cycle after edge N+k.
REQ-010 done SHALL be 1 exactly while the last bit is on sout (remaining=0, sout_valid=1), and 0 otherwise.
REQ-011 ready SHALL be 1 in IDLE, and 1 in SHIFT only when remaining=0; it SHALL be 0 for all other SHIFT cycles.
REQ-012 Back-to-back: an accept during the last-bit cycle SHALL drive the new word's first bit at the next edge, with no gap and sout_valid staying 1.
REQ-013 If load=0 during the last-bit cycle, the block SHALL return to IDLE at the next edge, giving sout=0 and sout_valid=0.
REQ-014 load with ready=0 SHALL be ignored, with no capture and no effect on the word in flight.
REQ-015 data_in changes after an accept SHALL NOT affect the bits being sent.
REQ-016 The internal shift register SHALL be WIDTH bits and shift toward the send end, filling with 0.
REQ-017 remaining SHALL never wrap below 0.

Reset
REQ-018 clear=1 at an edge SHALL force IDLE: sout=0, sout_valid=0, done=0, remaining=0, ready=1, shift register all-zero.
REQ-019 clear SHALL take priority over load in the same cycle, so no capture occurs.
REQ-020 clear mid-word SHALL abort the word with no done pulse; the first edge after clear deasserts SHALL accept a load normally.
REQ-021 Outputs before the first clear are unspecified; the bench SHALL assert clear for at least 2 edges at start.

Verification (WIDTH=6 unless stated)
REQ-022 MSB_FIRST=1: load 6'b101100 once -> sout 1,0,1,1,0,0 on the six following cycles; sout_valid=1 for all six; remaining 5..0; done only on the sixth; then IDLE.
REQ-023 MSB_FIRST=0: load 6'b101100 -> sout 0,0,1,1,0,1.
REQ-024 Back-to-back: load 6'b111000, then 6'b010101 on its done cycle -> twelve consecutive valid bits 1,1,1,0,0,0,0,1,0,1,0,1; two done pulses 6 cycles apart; no idle cycle.
REQ-025 Busy load: load 6'b110011, then assert load with 6'b000000 on cycles 2-4 -> output unchanged 1,1,0,0,1,1; ready=0 on cycles 1-5.
REQ-026 Clear mid-word: load 6'b111111, assert clear on cycle 3 -> sout=0, sout_valid=0 at the next edge, no done; a following load of 6'b100001 serializes correctly.
REQ-027 Loopback: sout feeds a 6-stage serial-in parallel-out capture register enabled by sout_valid -> after done, the captured word equals the loaded word for all 64 values.
